adder_station: RTL and testbench

- Adder-class functional unit with a single-entry reservation station: the consumer end of the instruction-issue bus and the producer end of the per-slot result bus.
- Captures an instruction issued to its FU number, reads operands from the register file/status, and snoops the result bus for pending tags.
- Executes ADD/SUB/ADDI/SUBI, then returns the result to the issuing reorder-buffer slot as a one-cycle valid pulse.

---
 rtl/adder_station_pkg.sv | 79 +++++++
 rtl/adder_station_operand_slot.sv | 51 +++++
 rtl/adder_station.sv | 208 ++++++++++++++++++++
 tb/tb_adder_station.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_station_pkg.sv
// Shared constants, types and result-bus lane helpers for the adder station.
// Optional protocol checking in adder_station is enabled by ADDER_STATION_CHECK_EN.
package adder_station_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int RB_SIZE      = 15;
    localparam int RB_INDEX     = 4;
    localparam int REG_INDEX    = 5;
    localparam int FU_INDEX     = 4;
    localparam int OPCODE_WIDTH = 6;
    localparam int IMM_WIDTH    = 16;

    localparam int OP_START = 26;
    localparam int RD_START = 21;
    localparam int RS_START = 16;
    localparam int RT_START = 11;

    localparam logic [RB_INDEX-1:0] READY = '1;
    localparam logic [FU_INDEX-1:0] NO_FU = '1;

    localparam logic [OPCODE_WIDTH-1:0] INST_ADD  = 6'h01;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUB  = 6'h02;
    localparam logic [OPCODE_WIDTH-1:0] INST_ADDI = 6'h03;
    localparam logic [OPCODE_WIDTH-1:0] INST_SUBI = 6'h04;

    typedef logic [WORD_SIZE-1:0]         word_t;
    typedef logic [RB_INDEX-1:0]          tag_t;
    typedef logic [RB_SIZE*WORD_SIZE-1:0] data_bus_t;
    typedef logic [RB_SIZE-1:0]           valid_bus_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPS,
        EXEC,
        DONE
    } state_t;

    function automatic logic readValidBus(
        input valid_bus_t bus,
        input tag_t       t
    );
        if (int'(t) >= RB_SIZE) return 1'b0;
        return bus[t];
    endfunction

    function automatic word_t readDataBus(
        input data_bus_t bus,
        input tag_t      t
    );
        if (int'(t) >= RB_SIZE) return '0;
        return bus[int'(t)*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic valid_bus_t writeValidBus(
        input tag_t t
    );
        valid_bus_t v;
        v = '0;
        if (int'(t) < RB_SIZE) v[t] = 1'b1;
        return v;
    endfunction

    function automatic data_bus_t writeDataBus(
        input tag_t  t,
        input word_t d
    );
        data_bus_t b;
        b = '0;
        if (int'(t) < RB_SIZE) b[int'(t)*WORD_SIZE +: WORD_SIZE] = d;
        return b;
    endfunction

    function automatic word_t sext_imm(
        input logic [IMM_WIDTH-1:0] imm
    );
        return {{(WORD_SIZE-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    endfunction

endpackage

// File: rtl/adder_station_operand_slot.sv
// One reservation-station operand: value plus producer tag, loaded at dispatch
// (with same-edge result-bus bypass) and resolved later by snooping the bus.
module operand_slot
    import adder_station_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  word_t      load_value,
    input  tag_t       load_tag,
    input  logic       snoop,
    input  data_bus_t  cdb_data,
    input  valid_bus_t cdb_valid,
    output word_t      value,
    output logic       capture,
    output tag_t       capture_tag,
    output logic       ready_next
);

    tag_t tag;
    tag_t watch;
    logic lane_hit;

    // At dispatch the incoming tag is watched, otherwise the held one.
    always_comb begin
        watch       = load ? load_tag : tag;
        lane_hit    = (watch != READY) && readValidBus(cdb_valid, watch);
        capture     = lane_hit && (load || snoop);
        capture_tag = watch;
        ready_next  = (watch == READY) || capture;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
            tag   <= READY;
        end else if (load) begin
            if (capture) begin
                value <= readDataBus(cdb_data, load_tag);
                tag   <= READY;
            end else begin
                value <= load_value;
                tag   <= load_tag;
            end
        end else if (capture) begin
            value <= readDataBus(cdb_data, tag);
            tag   <= READY;
        end
    end

endmodule

// File: rtl/adder_station.sv
// Adder functional unit with a single-entry reservation station (ADD/SUB/ADDI/SUBI).
// Define ADDER_STATION_CHECK_EN to enable the sticky protocol error flag err.
module adder_station
    import adder_station_pkg::*;
#(
    parameter int FU_ID   = 0,
    parameter int LATENCY = 1
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FU_INDEX-1:0]            CDB_inst_fu,
    input  logic [WORD_SIZE-1:0]           CDB_inst_inst,
    input  logic [RB_INDEX-1:0]            CDB_inst_RBindex,
    output logic [REG_INDEX-1:0]           numj,
    output logic [REG_INDEX-1:0]           numk,
    input  logic [WORD_SIZE-1:0]           vj,
    input  logic [WORD_SIZE-1:0]           vk,
    input  logic [RB_INDEX-1:0]            qj,
    input  logic [RB_INDEX-1:0]            qk,
    input  logic [RB_SIZE*WORD_SIZE-1:0]   CDB_data_data,
    input  logic [RB_SIZE-1:0]             CDB_data_valid,
    output logic [RB_SIZE*WORD_SIZE-1:0]   fu_data_data,
    output logic [RB_SIZE-1:0]             fu_data_valid,
    output logic                           busy,
    output logic                           err
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [FU_INDEX-1:0] MY_FU    = FU_INDEX'(FU_ID);

    logic [OPCODE_WIDTH-1:0] op;
    logic [REG_INDEX-1:0]    rs;
    logic [REG_INDEX-1:0]    rt;
    logic [IMM_WIDTH-1:0]    imm;
    logic                    unused_rd;

    state_t                  state;
    state_t                  state_nxt;
    logic                    select;
    logic                    is_r;
    logic                    is_i;
    logic                    op_ok;
    logic                    rb_ok;
    logic                    accept;
    logic                    load;
    logic                    snoop;
    logic                    sub_in;
    logic                    sub_q;
    tag_t                    rb_q;
    logic [CNT_W-1:0]        cnt;
    word_t                   res_q;

    word_t                   k_load_val;
    tag_t                    k_load_tag;
    word_t                   j_val;
    word_t                   k_val;
    logic                    j_cap;
    logic                    k_cap;
    tag_t                    j_cap_tag;
    tag_t                    k_cap_tag;
    logic                    j_rdy_nxt;
    logic                    k_rdy_nxt;

    assign op        = CDB_inst_inst[OP_START +: OPCODE_WIDTH];
    assign rs        = CDB_inst_inst[RS_START +: REG_INDEX];
    assign rt        = CDB_inst_inst[RT_START +: REG_INDEX];
    assign imm       = CDB_inst_inst[IMM_WIDTH-1:0];
    assign unused_rd = ^CDB_inst_inst[RD_START +: REG_INDEX];

    always_comb begin
        is_r = 1'b0;
        is_i = 1'b0;
        unique case (1'b1)
            (op == INST_ADD),
            (op == INST_SUB):  is_r = 1'b1;
            (op == INST_ADDI),
            (op == INST_SUBI): is_i = 1'b1;
            default: ;
        endcase
    end

    assign op_ok  = is_r || is_i;
    assign sub_in = (op == INST_SUB) || (op == INST_SUBI);
    assign rb_ok  = int'(CDB_inst_RBindex) < RB_SIZE;
    assign select = (CDB_inst_fu == MY_FU) && (CDB_inst_fu != NO_FU) && !busy;
    assign accept = select && op_ok && rb_ok;
    assign load   = (state == IDLE) && accept;
    assign snoop  = (state == WAIT_OPS);

    assign numj = select ? rs : {REG_INDEX{1'bz}};
    assign numk = (select && !is_i) ? rt : {REG_INDEX{1'bz}};

    assign k_load_val = is_i ? sext_imm(imm) : vk;
    assign k_load_tag = is_i ? READY : qk;

    operand_slot u_slot_j (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (vj),
        .load_tag    (qj),
        .snoop       (snoop),
        .cdb_data    (CDB_data_data),
        .cdb_valid   (CDB_data_valid),
        .value       (j_val),
        .capture     (j_cap),
        .capture_tag (j_cap_tag),
        .ready_next  (j_rdy_nxt)
    );

    operand_slot u_slot_k (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (k_load_val),
        .load_tag    (k_load_tag),
        .snoop       (snoop),
        .cdb_data    (CDB_data_data),
        .cdb_valid   (CDB_data_valid),
        .value       (k_val),
        .capture     (k_cap),
        .capture_tag (k_cap_tag),
        .ready_next  (k_rdy_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (j_rdy_nxt && k_rdy_nxt) ? EXEC : WAIT_OPS;
            end
            WAIT_OPS: begin
                if (j_rdy_nxt && k_rdy_nxt) state_nxt = EXEC;
            end
            EXEC: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_q <= 1'b0;
            rb_q  <= READY;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            if (load) begin
                sub_q <= sub_in;
                rb_q  <= CDB_inst_RBindex;
            end
            if (state_nxt == EXEC && state != EXEC)
                cnt <= CNT_LOAD;
            else if (state == EXEC && cnt != '0)
                cnt <= cnt - CNT_W'(1);
            // Wraps modulo 2^WORD_SIZE; no carry or overflow is kept.
            if (state == EXEC && cnt == '0)
                res_q <= sub_q ? (j_val - k_val) : (j_val + k_val);
        end
    end

    always_comb begin
        busy          = (state != IDLE);
        fu_data_valid = '0;
        fu_data_data  = '0;
        if (state == DONE) begin
            fu_data_valid = writeValidBus(rb_q);
            fu_data_data  = writeDataBus(rb_q, res_q);
        end
    end

`ifdef ADDER_STATION_CHECK_EN
    logic own_issue;
    logic err_set;
    logic err_q;
    tag_t self_tag;

    assign own_issue = (CDB_inst_fu == MY_FU) && (CDB_inst_fu != NO_FU);
    assign self_tag  = (state == IDLE) ? CDB_inst_RBindex : rb_q;
    assign err_set   = (own_issue && busy)
                    || (select && !op_ok)
                    || (select && !rb_ok)
                    || (j_cap && (j_cap_tag == self_tag))
                    || (k_cap && (k_cap_tag == self_tag));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{j_cap, k_cap, j_cap_tag, k_cap_tag};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_adder_station.sv
// Self-checking bench for adder_station: vector table plus scoreboard on the
// result bus, with hand-written pending-operand, bypass, busy and reset cases.
`timescale 1ns/1ps
module tb_adder_station;
    import adder_station_pkg::*;

    localparam int          LAT  = 1;
    localparam logic [3:0]  MYFU = 4'd0;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [FU_INDEX-1:0]          CDB_inst_fu;
    logic [WORD_SIZE-1:0]         CDB_inst_inst;
    logic [RB_INDEX-1:0]          CDB_inst_RBindex;
    logic [REG_INDEX-1:0]         numj;
    logic [REG_INDEX-1:0]         numk;
    logic [WORD_SIZE-1:0]         vj;
    logic [WORD_SIZE-1:0]         vk;
    logic [RB_INDEX-1:0]          qj;
    logic [RB_INDEX-1:0]          qk;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic [RB_SIZE*WORD_SIZE-1:0] fu_data_data;
    logic [RB_SIZE-1:0]           fu_data_valid;
    logic                         busy;
    logic                         err;

    adder_station #(.FU_ID(0), .LATENCY(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .CDB_inst_fu      (CDB_inst_fu),
        .CDB_inst_inst    (CDB_inst_inst),
        .CDB_inst_RBindex (CDB_inst_RBindex),
        .numj             (numj),
        .numk             (numk),
        .vj               (vj),
        .vk               (vk),
        .qj               (qj),
        .qk               (qk),
        .CDB_data_data    (CDB_data_data),
        .CDB_data_valid   (CDB_data_valid),
        .fu_data_data     (fu_data_data),
        .fu_data_valid    (fu_data_valid),
        .busy             (busy),
        .err              (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0]  rb;
        logic [31:0] data;
        int          at;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic [3:0]  rb;
        logic [31:0] res;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vt[6];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] ins;
    logic [RB_SIZE*WORD_SIZE-1:0] expd;
    logic [RB_SIZE-1:0]           expv;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input logic [5:0] op,
        input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 11'b0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op,
        input logic [4:0] rd, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b1 && fu_data_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 512'(fu_data_valid), 512'(0));
            end else begin
                mon_e = sb.pop_front();
                expv = '0;
                expv[mon_e.rb] = 1'b1;
                expd = '0;
                expd[int'(mon_e.rb)*32 +: 32] = mon_e.data;
                chk("result_valid", 512'(fu_data_valid), 512'(expv));
                chk("result_data", 512'(fu_data_data), 512'(expd));
                chk("result_latency", 512'(cyc), 512'(mon_e.at));
            end
        end
    end

    task automatic issue(input logic [3:0] fu, input logic [31:0] inst,
        input logic [3:0] rb, input logic [31:0] a, input logic [31:0] b,
        input logic [3:0] ta, input logic [3:0] tk, input bit push,
        input bit exp_busy, input logic [31:0] res);
        @(negedge clk);
        CDB_inst_fu      = fu;
        CDB_inst_inst    = inst;
        CDB_inst_RBindex = rb;
        vj = a;
        vk = b;
        qj = ta;
        qk = tk;
        #1;
        if (push) begin
            chk("numj", 512'(numj), 512'(inst[20:16]));
            if (inst[31:26] == INST_ADD || inst[31:26] == INST_SUB)
                chk("numk", 512'(numk), 512'(inst[15:11]));
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back('{rb, res, cyc + LAT});
        chk("busy_after_issue", 512'(busy), 512'(exp_busy));
        CDB_inst_fu    = NO_FU;
        CDB_data_valid = '0;
        CDB_data_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (!busy && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: busy=%0b pending=%0d expected idle",
                     name, busy, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        #1;
        chk("err_after_reset", 512'(err), 512'(0));
        reset = 1'b1;
    endtask

    task automatic lane(input int idx, input logic [31:0] d);
        CDB_data_valid[idx]        = 1'b1;
        CDB_data_data[idx*32 +: 32] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        CDB_inst_fu      = NO_FU;
        CDB_inst_inst    = '0;
        CDB_inst_RBindex = '0;
        vj = '0;
        vk = '0;
        qj = READY;
        qk = READY;
        CDB_data_data  = '0;
        CDB_data_valid = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("reset_busy", 512'(busy), 512'(0));
        chk("reset_valid", 512'(fu_data_valid), 512'(0));
        chk("reset_data", 512'(fu_data_data), 512'(0));
        chk("reset_err", 512'(err), 512'(0));
        @(negedge clk);
        reset = 1'b1;

        vt[0] = '{INST_ADD,  5'd1, 5'd2, 16'h0000, 32'd5,
                  32'd7,        READY, 4'd4,  32'd12};
        vt[1] = '{INST_SUBI, 5'd3, 5'd0, 16'hFFFF, 32'd3,
                  32'hDEADBEEF, 4'd5,  4'd7,  32'd4};
        vt[2] = '{INST_SUBI, 5'd4, 5'd0, 16'h0001, 32'd0,
                  32'hDEADBEEF, 4'd5,  4'd0,  32'hFFFFFFFF};
        vt[3] = '{INST_SUB,  5'd5, 5'd6, 16'h0000, 32'd10,
                  32'd3,        READY, 4'd14, 32'd7};
        vt[4] = '{INST_ADDI, 5'd7, 5'd0, 16'hFFF6, 32'd100,
                  32'd55,       4'd2,  4'd9,  32'd90};
        vt[5] = '{INST_ADD,  5'd8, 5'd9, 16'h0000, 32'hFFFFFFFF,
                  32'd1,        READY, 4'd1,  32'd0};

        for (int i = 0; i < 6; i++) begin
            if (vt[i].op == INST_ADDI || vt[i].op == INST_SUBI)
                ins = mk_i(vt[i].op, 5'd9, vt[i].rs, vt[i].imm);
            else
                ins = mk_r(vt[i].op, 5'd9, vt[i].rs, vt[i].rt);
            issue(MYFU, ins, vt[i].rb, vt[i].vj, vt[i].vk, READY, vt[i].qk,
                  1'b1, 1'b1, vt[i].res);
            wait_idle("vector");
        end

        // j pending on slot 6; an unrelated lane must not be captured
        issue(MYFU, mk_r(INST_ADD, 5'd3, 5'd6, 5'd7), 4'd3, 32'h0, 32'd1,
              4'd6, READY, 1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("wait_busy", 512'(busy), 512'(1));
            chk("wait_no_valid", 512'(fu_data_valid), 512'(0));
            CDB_data_valid = '0;
            CDB_data_data  = '0;
            if (i == 0) lane(5, 32'd55);
        end
        @(negedge clk);
        lane(6, 32'd100);
        @(posedge clk);
        #1;
        sb.push_back('{4'd3, 32'd101, cyc + LAT});
        CDB_data_valid = '0;
        CDB_data_data  = '0;
        wait_idle("wait_ops");

        // bypass: k resolves on the issue edge itself
        @(negedge clk);
        lane(2, 32'd9);
        issue(MYFU, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd5, 32'd1, 32'hBAD,
              READY, 4'd2, 1'b1, 1'b1, 32'd10);
        wait_idle("bypass");

        // second issue while busy must be ignored
        issue(MYFU, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd6, 32'd20, 32'd0,
              READY, 4'd8, 1'b0, 1'b1, 32'd0);
        issue(MYFU, mk_r(INST_SUB, 5'd2, 5'd3, 5'd4), 4'd7, 32'd1, 32'd1,
              READY, READY, 1'b0, 1'b1, 32'd0);
`ifdef ADDER_STATION_CHECK_EN
        chk("err_busy_issue", 512'(err), 512'(1));
`else
        chk("err_busy_issue", 512'(err), 512'(0));
`endif
        @(negedge clk);
        lane(8, 32'd22);
        @(posedge clk);
        #1;
        sb.push_back('{4'd6, 32'd42, cyc + LAT});
        CDB_data_valid = '0;
        CDB_data_data  = '0;
        wait_idle("busy_issue");

        // reset while in EXEC cuts the operation
        issue(MYFU, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd10, 32'd7, 32'd8,
              READY, READY, 1'b0, 1'b1, 32'd0);
        reset = 1'b0;
        #1;
        chk("midreset_busy", 512'(busy), 512'(0));
        chk("midreset_valid", 512'(fu_data_valid), 512'(0));
        chk("midreset_err", 512'(err), 512'(0));
        @(negedge clk);
        #1;
        chk("midreset_no_pulse", 512'(fu_data_valid), 512'(0));
        @(negedge clk);
        reset = 1'b1;
        issue(MYFU, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd11, 32'd30, 32'd12,
              READY, READY, 1'b1, 1'b1, 32'd42);
        wait_idle("after_reset");

        // unsupported opcode
        issue(MYFU, {6'h3F, 26'h0}, 4'd2, 32'd1, 32'd1, READY, READY,
              1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
`ifdef ADDER_STATION_CHECK_EN
        chk("err_bad_op", 512'(err), 512'(1));
`else
        chk("err_bad_op", 512'(err), 512'(0));
`endif
        do_reset();

        // RBindex equal to READY
        issue(MYFU, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd15, 32'd1, 32'd1,
              READY, READY, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
`ifdef ADDER_STATION_CHECK_EN
        chk("err_bad_rb", 512'(err), 512'(1));
`else
        chk("err_bad_rb", 512'(err), 512'(0));
`endif
        do_reset();

        // issue to another FU
        issue(4'd3, mk_r(INST_ADD, 5'd1, 5'd1, 5'd2), 4'd2, 32'd1, 32'd1,
              READY, READY, 1'b0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("other_fu_err", 512'(err), 512'(0));
        chk("sb_empty", 512'(sb.size()), 512'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
